// File: rtl/nios1_sw_poll_pkg.sv
// Shared definitions for the switch-poll controller: register map, FSM encoding, defaults.
package nios1_sw_poll_pkg;

  localparam int DATA_W_DEF   = 18;
  localparam int PERIOD_W_DEF = 24;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_MASK   = 2'd2;
  localparam logic [1:0] REG_EDGE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_READ    = 2'd2,
    ST_CAPTURE = 2'd3
  } poll_state_t;

endpackage

// File: rtl/nios1_sw_debounce.sv
// Switch debouncer: a value is accepted once DEBOUNCE consecutive polls agree; accepted changes
// are reported as a one-cycle edge_set vector in the same cycle stable updates.
module nios1_sw_debounce #(
  parameter int DATA_W   = 18,
  parameter int DEBOUNCE = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] stable,
  output logic [DATA_W-1:0] edge_set
);

  localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  logic [DATA_W-1:0] candidate, candidate_d;
  logic [DATA_W-1:0] stable_d;
  logic [CNT_W-1:0]  cnt, cnt_d;

  always_comb begin
    candidate_d = candidate;
    cnt_d       = cnt;
    stable_d    = stable;
    edge_set    = '0;
    if (sample_valid) begin
      if (sample == candidate) begin
        if (cnt != CNT_MAX) cnt_d = cnt + 1'b1;
      end else begin
        candidate_d = sample;
        cnt_d       = CNT_W'(1);
      end
      // Acceptance is judged on the updated candidate so DEBOUNCE=1 still works.
      if (cnt_d == CNT_MAX && candidate_d != stable) begin
        edge_set = candidate_d ^ stable;
        stable_d = candidate_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else begin
      candidate <= candidate_d;
      cnt       <= cnt_d;
      stable    <= stable_d;
    end
  end

endmodule

// File: rtl/nios1_sw_poll_ctrl.sv
// Periodically reads a switch PIO, debounces the value and raises a maskable edge interrupt.
// Slave handshake: s_write commits in its cycle; s_read returns data on s_readdata the next cycle.
module nios1_sw_poll_ctrl
  import nios1_sw_poll_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int PERIOD_W       = PERIOD_W_DEF,
  parameter int DEFAULT_PERIOD = 50000,
  parameter int DEBOUNCE       = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_write,
  input  logic        s_read,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  output logic        irq,
  output poll_state_t dbg_state
);

  poll_state_t         state, state_d;
  logic                enable, enable_d;
  logic [PERIOD_W-1:0] period, period_d;
  logic [PERIOD_W-1:0] count, count_d;
  logic [DATA_W-1:0]   mask, mask_d;
  logic [DATA_W-1:0]   edge_reg, edge_d, edge_w1c, edge_set;
  logic [DATA_W-1:0]   stable;
  logic [31:0]         rd_data;
  logic                sample_valid;
  logic                unused_bits;

  assign unused_bits = ^{s_writedata, m_readdata};
  assign m_address   = 2'b00;
  assign m_read      = (state == ST_READ);
  assign dbg_state   = state;

  // Register write decode; the FSM and irq consume the next-cycle values.
  always_comb begin
    enable_d = enable;
    period_d = period;
    mask_d   = mask;
    edge_w1c = '0;
    if (s_write) begin
      case (s_address)
        REG_CTRL:   enable_d = s_writedata[0];
        REG_PERIOD: period_d = (s_writedata[PERIOD_W-1:0] == '0) ? PERIOD_W'(1)
                                                                 : s_writedata[PERIOD_W-1:0];
        REG_MASK:   mask_d   = s_writedata[DATA_W-1:0];
        REG_EDGE:   edge_w1c = s_writedata[DATA_W-1:0];
      endcase
    end
    edge_d = (edge_reg & ~edge_w1c) | edge_set;
  end

  always_comb begin
    state_d = state;
    count_d = count;
    case (state)
      ST_IDLE:    if (enable) state_d = ST_WAIT;
      ST_WAIT:    if (count == '0) state_d = ST_READ;
                  else count_d = count - 1'b1;
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_WAIT;
    endcase
    if (!enable_d) state_d = ST_IDLE;
    if (state_d == ST_WAIT && state != ST_WAIT) count_d = period - 1'b1;
  end

  // A disable arriving in the capture cycle drops that sample.
  assign sample_valid = (state == ST_CAPTURE) && enable_d;

  nios1_sw_debounce #(
    .DATA_W   (DATA_W),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample       (m_readdata[DATA_W-1:0]),
    .stable       (stable),
    .edge_set     (edge_set)
  );

  always_comb begin
    rd_data = '0;
    case (s_address)
      REG_CTRL: begin
        rd_data[0]           = enable;
        rd_data[31 -: DATA_W] = stable;
      end
      REG_PERIOD: rd_data[PERIOD_W-1:0] = period;
      REG_MASK:   rd_data[DATA_W-1:0]   = mask;
      REG_EDGE:   rd_data[DATA_W-1:0]   = edge_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      enable     <= 1'b0;
      period     <= PERIOD_W'(DEFAULT_PERIOD);
      count      <= '0;
      mask       <= '0;
      edge_reg   <= '0;
      s_readdata <= '0;
      irq        <= 1'b0;
    end else begin
      state    <= state_d;
      enable   <= enable_d;
      period   <= period_d;
      count    <= count_d;
      mask     <= mask_d;
      edge_reg <= edge_d;
      irq      <= |(edge_d & mask_d);
      if (s_read) s_readdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_nios1_sw_poll_ctrl.sv
// Directed bench for nios1_sw_poll_ctrl: register access, poll timing, debounce, W1C and reset abort.
module tb_nios1_sw_poll_ctrl;
  import nios1_sw_poll_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  s_address;
  logic        s_write, s_read;
  logic [31:0] s_writedata, s_readdata;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic        irq;
  poll_state_t dbg_state;
  logic [17:0] sw;

  int checks = 0;
  int errors = 0;

  assign m_readdata = {14'b0, sw};

  nios1_sw_poll_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_address   (s_address),
    .s_write     (s_write),
    .s_read      (s_read),
    .s_writedata (s_writedata),
    .s_readdata  (s_readdata),
    .m_address   (m_address),
    .m_read      (m_read),
    .m_readdata  (m_readdata),
    .irq         (irq),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    s_address = a; s_read = 1'b1;
    @(negedge clk);
    s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic wait_state(input poll_state_t st, input string tag);
    int n = 0;
    while (dbg_state != st && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dbg_state == st), 32'd1);
  endtask

  // Returns the number of negedges until m_read is seen high.
  task automatic wait_mread(output int n, input string tag);
    logic found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      found = m_read;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  logic [31:0] rd;
  int          n, highs;

  initial begin
    reset_n = 1'b0; s_address = 2'd0; s_write = 1'b0; s_read = 1'b0; s_writedata = '0; sw = '0;
    repeat (3) @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_mread", 32'(m_read), 32'd0);
    check("rst_readdata", s_readdata, 32'd0);
    check("rst_maddr", 32'(m_address), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    bus_read(REG_CTRL, rd);   check("rst_ctrl", rd, 32'd0);
    bus_read(REG_PERIOD, rd); check("rst_period", rd, 32'd50000);
    bus_read(REG_MASK, rd);   check("rst_mask", rd, 32'd0);
    bus_read(REG_EDGE, rd);   check("rst_edge", rd, 32'd0);

    // Poll at PERIOD=4: first m_read 5 cycles after enable lands, then every 6 cycles.
    bus_write(REG_PERIOD, 32'd4);
    bus_read(REG_PERIOD, rd); check("period_rb", rd, 32'd4);
    sw = 18'h00005;
    bus_write(REG_CTRL, 32'd1);
    wait_mread(n, "first_mread_to");
    check("first_latency", 32'(n), 32'd5);
    @(negedge clk);
    check("mread_width", 32'(m_read), 32'd0);
    wait_mread(n, "second_mread_to");
    check("poll_interval", 32'(n + 1), 32'd6);
    repeat (3) @(negedge clk);
    bus_read(REG_CTRL, rd); check("stable_5", rd, 32'h0001_4001);
    bus_read(REG_EDGE, rd); check("edge_5", rd, 32'h0000_0005);
    check("irq_masked", 32'(irq), 32'd0);

    // Mask bit 0 raises irq; W1C of bit 0 drops it and leaves bit 2.
    bus_write(REG_MASK, 32'h1);
    check("irq_set", 32'(irq), 32'd1);
    bus_write(REG_EDGE, 32'h1);
    check("irq_clr", 32'(irq), 32'd0);
    bus_read(REG_EDGE, rd); check("edge_after_w1c", rd, 32'h4);

    // One-poll glitch on bit 3 must not be accepted.
    wait_state(ST_READ, "glitch_read_to");
    sw = 18'h0000D;
    @(negedge clk);
    @(negedge clk);
    sw = 18'h00005;
    wait_mread(n, "glitch_p1_to");
    wait_mread(n, "glitch_p2_to");
    repeat (3) @(negedge clk);
    bus_read(REG_EDGE, rd); check("glitch_edge", rd, 32'h4);
    bus_read(REG_CTRL, rd); check("glitch_stable", rd, 32'h0001_4001);

    // W1C of bit 2 in the very cycle a new bit-2 edge is set: the set wins.
    bus_write(REG_EDGE, 32'h4);
    bus_read(REG_EDGE, rd); check("edge_cleared", rd, 32'h0);
    wait_state(ST_CAPTURE, "race_cap0_to");
    @(negedge clk);
    sw = 18'h00001;
    wait_state(ST_CAPTURE, "race_cap1_to");
    @(negedge clk);
    wait_state(ST_CAPTURE, "race_cap2_to");
    s_address = REG_EDGE; s_writedata = 32'h4; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
    repeat (2) @(negedge clk);
    bus_read(REG_EDGE, rd); check("race_edge", rd, 32'h4);
    bus_read(REG_CTRL, rd); check("race_stable", rd, 32'h0000_4001);
    check("race_irq", 32'(irq), 32'd0);

    // Disable during READ: straight to IDLE, no further strobes.
    sw = 18'h00003;
    wait_state(ST_READ, "dis_read_to");
    check("dis_mread_hi", 32'(m_read), 32'd1);
    s_address = REG_CTRL; s_writedata = 32'h0; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
    check("dis_mread_lo", 32'(m_read), 32'd0);
    check("dis_state", 32'(dbg_state), 32'(ST_IDLE));
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_read) highs++;
    end
    check("dis_quiet", 32'(highs), 32'd0);
    bus_read(REG_CTRL, rd); check("dis_ctrl", rd, 32'h0000_4000);
    bus_write(REG_PERIOD, 32'h0);
    bus_read(REG_PERIOD, rd); check("period_zero", rd, 32'd1);

    // Reset during CAPTURE with changed switches.
    bus_write(REG_MASK, 32'h3FFFF);
    sw = 18'h2AAAA;
    bus_write(REG_CTRL, 32'd1);
    wait_state(ST_CAPTURE, "rst_cap_to");
    reset_n = 1'b0;
    #1;
    check("midrst_irq", 32'(irq), 32'd0);
    check("midrst_mread", 32'(m_read), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_read) highs++;
    end
    check("midrst_quiet", 32'(highs), 32'd0);
    bus_read(REG_CTRL, rd);   check("midrst_ctrl", rd, 32'd0);
    bus_read(REG_PERIOD, rd); check("midrst_period", rd, 32'd50000);
    bus_read(REG_MASK, rd);   check("midrst_mask", rd, 32'd0);
    bus_read(REG_EDGE, rd);   check("midrst_edge", rd, 32'd0);
    check("midrst_irq2", 32'(irq), 32'd0);
    bus_write(REG_PERIOD, 32'd2);
    bus_write(REG_CTRL, 32'd1);
    wait_mread(n, "resume_to");
    check("resume_latency", 32'(n), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
